// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: parametrised, pipelined barrel shifter / rotator with valid/ready flow control.
//
// Every mode is computed as a right move. Left modes (ROTL, SHL) bit-reverse the operand on
// entry and bit-reverse the result on exit, so the level network only ever moves data towards
// the LSB. Level k moves by 2^k when shift bit k is set. The SW levels are split across STAGES
// register stages, ceil(SW/STAGES) levels per stage starting at k=0. The last stage takes
// whatever is left, which may be nothing.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset; drops all in-flight beats
//   in_mode_i    0 ROTR, 1 ROTL, 2 SHR, 3 SHL, 4 SRA, 5..7 illegal (operand passes, err set)
//   in_shift_i   shift amount 0..WIDTH-1
//   in_data_i    operand
//   in_valid_i   input beat valid
//   in_ready_o   input beat accepted this cycle if valid
//   out_data_o   result (registered)
//   out_err_o    result came from an illegal mode
//   out_valid_o  result valid
//   out_ready_i  downstream accepts result
module barrel_shift_pipe #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2,
  parameter int unsigned SW     = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       in_mode_i,
  input  logic [SW-1:0]    in_shift_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_err_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  localparam int unsigned Levels   = SW;
  localparam int unsigned PerStage = (Levels + STAGES - 1) / STAGES;
  localparam int unsigned Last     = STAGES - 1;

  localparam logic [2:0] ModeRotr = 3'd0;
  localparam logic [2:0] ModeRotl = 3'd1;
  localparam logic [2:0] ModeShr  = 3'd2;
  localparam logic [2:0] ModeShl  = 3'd3;
  localparam logic [2:0] ModeSra  = 3'd4;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  function automatic logic mode_is_left(input logic [2:0] mode);
    return (mode == ModeRotl) || (mode == ModeShl);
  endfunction

  function automatic logic mode_is_legal(input logic [2:0] mode);
    return mode <= ModeSra;
  endfunction

  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[i] = d[int'(WIDTH) - 1 - i];
    end
    return r;
  endfunction

  // One level of the network: move d towards the LSB by 2^k.
  function automatic logic [WIDTH-1:0] level_move(input logic [WIDTH-1:0] d,
                                                  input int            k,
                                                  input logic [2:0]    mode,
                                                  input logic          sign);
    int unsigned      amt;
    logic [WIDTH-1:0] fill;
    logic [WIDTH-1:0] r;
    amt  = 32'd1 << k;
    fill = ~({WIDTH{1'b1}} >> amt);
    unique case (mode)
      ModeRotr, ModeRotl: r = (d >> amt) | (d << (WIDTH - amt));
      ModeShr, ModeShl:   r = d >> amt;
      ModeSra:            r = (d >> amt) | (sign ? fill : '0);
      default:            r = d;
    endcase
    return r;
  endfunction

  // Apply levels lo..hi-1 whose shift bit is set.
  function automatic logic [WIDTH-1:0] run_levels(input logic [WIDTH-1:0] d,
                                                  input logic [SW-1:0]    sh,
                                                  input logic [2:0]       mode,
                                                  input logic             sign,
                                                  input int               lo,
                                                  input int               hi);
    logic [WIDTH-1:0] r;
    r = d;
    for (int k = 0; k < int'(Levels); k++) begin
      if ((k >= lo) && (k < hi) && sh[k]) begin
        r = level_move(r, k, mode, sign);
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------------

  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [SW-1:0]     shift_q [STAGES];
  logic [2:0]        mode_q  [STAGES];
  logic [STAGES-1:0] sign_q;
  logic [STAGES-1:0] valid_q;

  // Per-stage inputs (from the port for stage 0, from the previous register otherwise) and the
  // next-state data each stage would capture.
  logic [WIDTH-1:0]  st_in_data  [STAGES];
  logic [SW-1:0]     st_in_shift [STAGES];
  logic [2:0]        st_in_mode  [STAGES];
  logic [STAGES-1:0] st_in_sign;
  logic [STAGES-1:0] st_in_valid;
  logic [WIDTH-1:0]  st_out_data [STAGES];

  logic [STAGES-1:0] load;
  logic [STAGES-1:0] adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int LoLvl = s * int'(PerStage);
    localparam int HiLvl = (s + 1) * int'(PerStage);

    if (s == 0) begin : g_head
      // Illegal modes force the shift to zero so the operand passes through unmodified.
      assign st_in_data[s]  = mode_is_left(in_mode_i) ? bit_reverse(in_data_i) : in_data_i;
      assign st_in_shift[s] = mode_is_legal(in_mode_i) ? in_shift_i : '0;
      assign st_in_mode[s]  = in_mode_i;
      assign st_in_sign[s]  = in_data_i[WIDTH-1];
      assign st_in_valid[s] = in_valid_i;
    end else begin : g_body
      assign st_in_data[s]  = data_q[s-1];
      assign st_in_shift[s] = shift_q[s-1];
      assign st_in_mode[s]  = mode_q[s-1];
      assign st_in_sign[s]  = sign_q[s-1];
      assign st_in_valid[s] = valid_q[s-1];
    end

    if (s == int'(Last)) begin : g_tail
      // Undo the entry reversal so left-mode results leave the stage in natural bit order.
      logic [WIDTH-1:0] moved;
      assign moved = run_levels(st_in_data[s], st_in_shift[s], st_in_mode[s], st_in_sign[s],
                                LoLvl, HiLvl);
      assign st_out_data[s] = mode_is_left(st_in_mode[s]) ? bit_reverse(moved) : moved;
    end else begin : g_mid
      assign st_out_data[s] = run_levels(st_in_data[s], st_in_shift[s], st_in_mode[s],
                                         st_in_sign[s], LoLvl, HiLvl);
    end
  end

  // ---------------------------------------------------------------------------
  // Flow control: ready ripples back from the output. A stage loads when it is empty or when
  // its current beat moves on this cycle, so bubbles fill even while the output is stalled.
  // ---------------------------------------------------------------------------

  always_comb begin
    logic down_ready;
    load       = '0;
    adv        = '0;
    down_ready = out_ready_i;
    for (int s = int'(Last); s >= 0; s--) begin
      adv[s]     = valid_q[s] && down_ready;
      load[s]    = !valid_q[s] || down_ready;
      down_ready = load[s];
    end
  end

  assign in_ready_o = load[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      sign_q  <= '0;
      for (int s = 0; s < int'(STAGES); s++) begin
        data_q[s]  <= '0;
        shift_q[s] <= '0;
        mode_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < int'(STAGES); s++) begin
        if (load[s]) begin
          valid_q[s] <= st_in_valid[s];
          // Payload only changes when a real beat arrives, keeping the output quiet on bubbles.
          if (st_in_valid[s]) begin
            data_q[s]  <= st_out_data[s];
            shift_q[s] <= st_in_shift[s];
            mode_q[s]  <= st_in_mode[s];
            sign_q[s]  <= st_in_sign[s];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------

  assign out_data_o  = data_q[Last];
  assign out_valid_o = valid_q[Last];
  assign out_err_o   = !mode_is_legal(mode_q[Last]);

  // The last stage's shift/sign copies and the advance vector are bookkeeping only.
  logic unused_tail;
  assign unused_tail = ^{shift_q[Last], sign_q[Last], adv};

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;

  localparam int unsigned W = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   mode;
  logic [5:0]   shift;
  logic [63:0]  data;
  logic         in_valid, in_ready, out_ready, out_valid, out_err;
  logic [63:0]  out_data;

  logic         aux_valid;
  logic         a1_ready, a1_valid, a1_err;
  logic [63:0]  a1_data;
  logic         a6_ready, a6_valid, a6_err;
  logic [63:0]  a6_data;

  barrel_shift_pipe #(.WIDTH(W), .STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst), .in_mode_i(mode), .in_shift_i(shift), .in_data_i(data),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .out_data_o(out_data), .out_err_o(out_err),
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  barrel_shift_pipe #(.WIDTH(W), .STAGES(1)) dut_s1 (
    .clk_i(clk), .rst_i(rst), .in_mode_i(mode), .in_shift_i(shift), .in_data_i(data),
    .in_valid_i(aux_valid), .in_ready_o(a1_ready), .out_data_o(a1_data), .out_err_o(a1_err),
    .out_valid_o(a1_valid), .out_ready_i(1'b1)
  );

  barrel_shift_pipe #(.WIDTH(W), .STAGES(6)) dut_s6 (
    .clk_i(clk), .rst_i(rst), .in_mode_i(mode), .in_shift_i(shift), .in_data_i(data),
    .in_valid_i(aux_valid), .in_ready_o(a6_ready), .out_data_o(a6_data), .out_err_o(a6_err),
    .out_valid_o(a6_valid), .out_ready_i(1'b1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {err, result}.
  function automatic logic [64:0] ref_op(input logic [2:0] m, input logic [5:0] n,
                                         input logic [63:0] d);
    logic [63:0] r;
    int unsigned k;
    k = n;
    case (m)
      3'd0:    r = (d >> k) | (d << (64 - k));
      3'd1:    r = (d << k) | (d >> (64 - k));
      3'd2:    r = d >> k;
      3'd3:    r = d << k;
      3'd4:    r = $signed(d) >>> k;
      default: return {1'b1, d};
    endcase
    return {1'b0, r};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboards, sampled on the falling edge
  // ---------------------------------------------------------------------------
  logic [64:0] q_main[$];
  logic [64:0] q_a1[$];
  logic [64:0] q_a6[$];
  bit          mon_en = 1'b0;
  int          n_in = 0, n_out = 0, n_a1 = 0, n_a6 = 0;
  bit          hold = 1'b0;
  logic [63:0] hold_data;
  logic        hold_err;

  always @(negedge clk) begin
    logic [64:0] e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (mon_en) begin
        if (hold) begin
          check("stall_valid_held", 64'(out_valid), 64'd1);
          check("stall_data_stable", out_data, hold_data);
          check("stall_err_stable", 64'(out_err), 64'(hold_err));
        end
        hold      = out_valid && !out_ready;
        hold_data = out_data;
        hold_err  = out_err;
        if (in_valid && in_ready) begin
          q_main.push_back(ref_op(mode, shift, data));
          n_in++;
        end
        if (out_valid && out_ready) begin
          n_out++;
          if (q_main.size() == 0) begin
            checks++; errors++;
            $display("FAIL main_extra_beat: got %h expected no beat", out_data);
          end else begin
            e = q_main.pop_front();
            check("main_data", out_data, e[63:0]);
            check("main_err", 64'(out_err), 64'(e[64]));
          end
        end
      end
      if (aux_valid && a1_ready) q_a1.push_back(ref_op(mode, shift, data));
      if (aux_valid && a6_ready) q_a6.push_back(ref_op(mode, shift, data));
      if (a1_valid) begin
        n_a1++;
        if (q_a1.size() == 0) begin
          checks++; errors++;
          $display("FAIL s1_extra_beat: got %h expected no beat", a1_data);
        end else begin
          e = q_a1.pop_front();
          check("s1_data", a1_data, e[63:0]);
          check("s1_err", 64'(a1_err), 64'(e[64]));
        end
      end
      if (a6_valid) begin
        n_a6++;
        if (q_a6.size() == 0) begin
          checks++; errors++;
          $display("FAIL s6_extra_beat: got %h expected no beat", a6_data);
        end else begin
          e = q_a6.pop_front();
          check("s6_data", a6_data, e[63:0]);
          check("s6_err", 64'(a6_err), 64'(e[64]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    while ((q_main.size() != 0 || out_valid) && c < 100) begin
      tick();
      c++;
    end
    check(name, 64'(q_main.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0]  mode;
    logic [5:0]  shift;
    logic [63:0] data;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  localparam int NVec = 16;
  vec_t vecs[NVec];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc;

    vecs[0]  = '{3'd0, 6'd4,  64'h0123456789abcdef, 64'hf0123456789abcde, 1'b0};
    vecs[1]  = '{3'd1, 6'd8,  64'h0123456789abcdef, 64'h23456789abcdef01, 1'b0};
    vecs[2]  = '{3'd2, 6'd4,  64'hfedcba9876543210, 64'h0fedcba987654321, 1'b0};
    vecs[3]  = '{3'd4, 6'd4,  64'hfedcba9876543210, 64'hffedcba987654321, 1'b0};
    vecs[4]  = '{3'd3, 6'd63, 64'h0123456789abcdef, 64'h8000000000000000, 1'b0};
    vecs[5]  = '{3'd2, 6'd63, 64'h0123456789abcdef, 64'h0000000000000000, 1'b0};
    vecs[6]  = '{3'd6, 6'd12, 64'h00000000deadbeef, 64'h00000000deadbeef, 1'b1};
    vecs[7]  = '{3'd0, 6'd12, 64'h00000000deadbeef, 64'heef00000000deadb, 1'b0};
    vecs[8]  = '{3'd4, 6'd0,  64'hfedcba9876543210, 64'hfedcba9876543210, 1'b0};
    vecs[9]  = '{3'd3, 6'd0,  64'h0123456789abcdef, 64'h0123456789abcdef, 1'b0};
    vecs[10] = '{3'd0, 6'd63, 64'h0123456789abcdef, 64'h02468acf13579bde, 1'b0};
    vecs[11] = '{3'd4, 6'd63, 64'hfedcba9876543210, 64'hffffffffffffffff, 1'b0};
    vecs[12] = '{3'd1, 6'd4,  64'hfedcba9876543210, 64'hedcba9876543210f, 1'b0};
    vecs[13] = '{3'd5, 6'd1,  64'h0123456789abcdef, 64'h0123456789abcdef, 1'b1};
    vecs[14] = '{3'd3, 6'd4,  64'h0123456789abcdef, 64'h123456789abcdef0, 1'b0};
    vecs[15] = '{3'd4, 6'd8,  64'h0123456789abcdef, 64'h000123456789abcd, 1'b0};

    rst = 1'b1; in_valid = 1'b0; aux_valid = 1'b0; out_ready = 1'b1;
    mode = '0; shift = '0; data = '0;
    repeat (3) tick();
    rst = 1'b0;
    #3;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_err", 64'(out_err), 64'd0);
    check("reset_out_data", out_data, 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Single beats through an empty pipe: result, error flag and latency.
    for (int i = 0; i < NVec; i++) begin
      tick();
      mode = vecs[i].mode; shift = vecs[i].shift; data = vecs[i].data; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      check($sformatf("vec%0d_err", i), 64'(out_err), 64'(vecs[i].err));
    end
    tick();

    // Back-to-back sweep on all three depths.
    mon_en = 1'b1;
    n_in = 0; n_out = 0; n_a1 = 0; n_a6 = 0;
    for (int m = 0; m < 5; m++) begin
      for (int s = 0; s < 64; s++) begin
        mode = 3'(m); shift = 6'(s);
        data = s[0] ? 64'hfedcba9876543210 : 64'h0123456789abcdef;
        in_valid = 1'b1; aux_valid = 1'b1;
        check("sweep_in_ready", 64'(in_ready), 64'd1);
        tick();
      end
    end
    in_valid = 1'b0; aux_valid = 1'b0;
    repeat (10) tick();
    check("sweep_main_count", 64'(n_out), 64'd320);
    check("sweep_s1_count", 64'(n_a1), 64'd320);
    check("sweep_s6_count", 64'(n_a6), 64'd320);
    check("sweep_queues_empty", 64'(q_main.size() + q_a1.size() + q_a6.size()), 64'd0);

    // Output stalled for 10 cycles under continuous input: exactly two beats fit.
    out_ready = 1'b0; in_valid = 1'b1; mode = 3'd0; shift = 6'd1;
    data = 64'h1000;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (in_ready) acc++;
      tick();
      if (acc > 0) data = 64'h1000 + 64'(acc);
    end
    check("stall_accepted", 64'(acc), 64'd2);
    check("stall_in_ready_low", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      data = data + 64'd1;
    end
    in_valid = 1'b0;
    drain("stall_drain");

    // Random traffic.
    n_in = 0; n_out = 0;
    begin
      int cyc;
      cyc = 0;
      while (n_in < 1000 && cyc < 20000) begin
        in_valid  = ($urandom_range(3) != 0);
        out_ready = ($urandom_range(9) < 6);
        mode  = 3'($urandom_range(7));
        shift = 6'($urandom_range(63));
        data  = {$urandom(), $urandom()};
        tick();
        cyc++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain("random_drain");
    check("random_in_count", 64'(n_in), 64'd1000);
    check("random_out_count", 64'(n_out), 64'd1000);

    // Reset with two beats stranded in a stalled pipe.
    out_ready = 1'b0; in_valid = 1'b1; mode = 3'd2; shift = 6'd3; data = 64'hffff;
    tick();
    data = 64'heeee;
    tick();
    in_valid = 1'b0;
    check("prereset_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_main.delete();
    #1;
    check("postreset_out_valid", 64'(out_valid), 64'd0);
    check("postreset_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    n_out = 0;
    repeat (10) tick();
    check("postreset_no_stale", 64'(n_out), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
